wb_bus_arbiter: RTL
===================

# wb_bus_arbiter

Round-robin Wishbone B4 pipelined bus arbiter that shares one slave port among N_MASTERS NIC Wishbone master interfaces. It drives the per-master `gnt_wb_o` grant each master waits for before transferring. It multiplexes the granted master's request onto the slave and routes ACK/RTY/ERR/STALL back to that master only. A watchdog aborts a transfer whose slave stops answering.

## Interface
- N_MASTERS, 4: number of requesting masters (2..16).
- TIMEOUT_CYCLES, 64: consecutive owned cycles with no slave ACK/RTY/ERR before abort; 0 disables the watchdog.
- Widths `BUS_ADDRESS_WIDTH` (AW), `BUS_DATA_WIDTH` (DW) and `BUS_DATA_WIDTH/GRANULARITY` (SW) come from NIC-defines.v.

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- gnt_wb_o  out  N_MASTERS  one-hot grant, registered
- M_CYC_I, M_STB_I, M_WE_I  in  N_MASTERS each  per-master cycle, strobe and write enable
- M_ADR_I  in  N_MASTERS*AW  flattened; master k occupies [(k+1)*AW-1:k*AW]
- M_DAT_I  in  N_MASTERS*DW  flattened write data
- M_SEL_I  in  N_MASTERS*SW  flattened byte selects
- M_CTI_I  in  N_MASTERS*3  flattened cycle type
- M_DAT_O  out  DW  S_DAT_I broadcast to all masters
- M_ACK_O, M_RTY_O, M_ERR_O, M_STALL_O  out  N_MASTERS each  per-master responses
- S_CYC_O, S_STB_O, S_WE_O  out  1 each  to slave
- S_ADR_O  out  AW; S_DAT_O  out  DW; S_SEL_O  out  SW; S_CTI_O  out  3  to slave
- S_DAT_I  in  DW; S_ACK_I, S_RTY_I, S_ERR_I, S_STALL_I  in  1 each  from slave
- owner_o  out  4  index of current owner (valid when busy_o)
- busy_o  out  1  grant held

## Operation
- State register holds one of three states: IDLE, OWNED, ABORT. Registers: owner, ptr (round-robin start, 0..N-1), wdog counter.
- Arbitration: search M_CYC_I from ptr upward, modulo N. The first asserted index wins.
- IDLE: if any M_CYC_I is set, owner becomes the winner, gnt_wb_o[winner] is set, the state goes to OWNED and wdog is cleared.
- OWNED:
  - If M_CYC_I[owner]=0, ptr becomes owner+1 mod N. Arbitration runs in the same cycle with the current owner excluded. If there is a winner, the grant hands off directly (no bubble). Otherwise gnt_wb_o is cleared and the state goes to IDLE.
  - Else if S_ACK_I, S_RTY_I or S_ERR_I is asserted, wdog clears.
  - Else if TIMEOUT_CYCLES≠0, wdog increments. When wdog reaches TIMEOUT_CYCLES-1, the state goes to ABORT.
- ABORT:
  - M_ERR_O[owner]=1 for exactly the first ABORT cycle.
  - S_CYC_O and S_STB_O are forced to 0 for the whole ABORT state.
  - The state waits for M_CYC_I[owner]=0, then releases exactly as in OWNED.
- Slave mux (combinational from the registered owner):
  - S_CYC_O = M_CYC_I[owner] and S_STB_O = M_STB_I[owner], in OWNED only.
  - S_WE_O, S_ADR_O, S_DAT_O, S_SEL_O and S_CTI_O come from owner's slice when busy_o; they are all 0 otherwise.
- Master responses:
  - Owner in OWNED: M_ACK_O, M_RTY_O and M_ERR_O follow the slave inputs; M_STALL_O = S_STALL_I.
  - Every non-owner, and every master in IDLE: ACK/RTY/ERR = 0, STALL = 1.
  - Owner in ABORT: STALL = 1; ACK and RTY = 0.
- Non-owner strobes are ignored. They are not errors.

## Timing
- Reset values:
  - State, registers and grant: state IDLE, ptr 0, owner 0, wdog 0, gnt_wb_o 0, busy_o 0.
  - Slave side: S_* outputs 0.
  - Master side: M_ACK_O, M_RTY_O, M_ERR_O 0; M_STALL_O all 1.
- Reset has priority over every transition, including mid-transfer. The grant drops on the reset edge; the slave sees S_CYC_O fall in the same cycle.
- Grant latency: M_CYC_I sampled at edge t gives gnt_wb_o set after edge t. The slave mux is live in the same cycle.
- Handoff: owner's CYC seen low at edge t gives the new grant after edge t. There is no idle cycle between owners.
- Simultaneous requests: lowest index at or above ptr wins. After owner k releases, index k has the lowest priority.
- If CYC falls and rises again in consecutive cycles with no other requester, the same master is re-granted one cycle later via IDLE.
- Watchdog: the first ERR appears TIMEOUT_CYCLES cycles after the last slave response, or after the grant if the slave never responded.

## Test plan
- Single request, N=4: M_CYC_I=0001 at edge 1 → gnt_wb_o=0001 after edge 1. Write ADR=0x10, DAT=0xA5 reaches S_ADR_O/S_DAT_O. Slave ACK maps to M_ACK_O[0] only.
- Contention: M_CYC_I=1111 held; each owner holds CYC 3 cycles → grant order 0,1,2,3,0. Each handoff has zero bubble.
- Non-owner isolation: master 2 strobes while master 1 owns → M_STALL_O[2]=1, M_ACK_O[2]=0, slave sees only master 1's address.
- Watchdog, TIMEOUT_CYCLES=8: slave never responds → M_ERR_O[owner] pulses once 8 cycles after grant and S_CYC_O drops. After the owner drops CYC, the next requester is granted.
- Reset mid-transfer: assert rst while master 3 owns with 2 ACKs pending → next cycle gnt_wb_o=0, S_CYC_O=0, ptr=0. After release with M_CYC_I=1010, master 1 wins.
- Release to idle: sole owner drops CYC → gnt_wb_o=0 after that edge, busy_o=0, all M_STALL_O=1.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - round-robin Wishbone B4 pipelined arbiter sharing one slave port
module wb_bus_arbiter #(
  parameter int N_MASTERS         = 4,
  parameter int TIMEOUT_CYCLES    = 64,
  parameter int BUS_ADDRESS_WIDTH = 32,
  parameter int BUS_DATA_WIDTH    = 32,
  parameter int GRANULARITY       = 8,
  localparam int AW = BUS_ADDRESS_WIDTH,
  localparam int DW = BUS_DATA_WIDTH,
  localparam int SW = BUS_DATA_WIDTH / GRANULARITY
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [N_MASTERS-1:0]    gnt_wb_o,
  input  logic [N_MASTERS-1:0]    M_CYC_I,
  input  logic [N_MASTERS-1:0]    M_STB_I,
  input  logic [N_MASTERS-1:0]    M_WE_I,
  input  logic [N_MASTERS*AW-1:0] M_ADR_I,
  input  logic [N_MASTERS*DW-1:0] M_DAT_I,
  input  logic [N_MASTERS*SW-1:0] M_SEL_I,
  input  logic [N_MASTERS*3-1:0]  M_CTI_I,
  output logic [DW-1:0]           M_DAT_O,
  output logic [N_MASTERS-1:0]    M_ACK_O,
  output logic [N_MASTERS-1:0]    M_RTY_O,
  output logic [N_MASTERS-1:0]    M_ERR_O,
  output logic [N_MASTERS-1:0]    M_STALL_O,
  output logic                    S_CYC_O,
  output logic                    S_STB_O,
  output logic                    S_WE_O,
  output logic [AW-1:0]           S_ADR_O,
  output logic [DW-1:0]           S_DAT_O,
  output logic [SW-1:0]           S_SEL_O,
  output logic [2:0]              S_CTI_O,
  input  logic [DW-1:0]           S_DAT_I,
  input  logic                    S_ACK_I,
  input  logic                    S_RTY_I,
  input  logic                    S_ERR_I,
  input  logic                    S_STALL_I,
  output logic [3:0]              owner_o,
  output logic                    busy_o
);

  localparam int OW = $clog2(N_MASTERS);
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WDOG_LAST = (TIMEOUT_CYCLES > 0) ? WW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [N_MASTERS-1:0] ONE = {{(N_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, OWNED, ABORT} state_t;

  state_t         state;
  logic [OW-1:0]  owner;
  logic [OW-1:0]  ptr;
  logic [WW-1:0]  wdog;
  logic           abort_first;

  logic           owner_cyc;
  logic           releasing;
  logic [OW-1:0]  ptr_next;
  logic [OW-1:0]  arb_start;
  logic [N_MASTERS-1:0] arb_req;
  logic           arb_found;
  logic [OW-1:0]  arb_idx;
  logic [OW:0]    cand;

  assign owner_cyc = M_CYC_I[owner];
  assign releasing = (state != IDLE) && !owner_cyc;
  assign ptr_next  = (owner == OW'(N_MASTERS - 1)) ? '0 : owner + OW'(1);
  assign arb_start = releasing ? ptr_next : ptr;
  assign arb_req   = M_CYC_I & ~(releasing ? (ONE << owner) : '0);
  assign busy_o    = (state != IDLE);
  assign owner_o   = 4'(owner);
  assign M_DAT_O   = S_DAT_I;

  // Round-robin search: first requester at or above arb_start, wrapping modulo N.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      cand = {1'b0, arb_start} + (OW+1)'(i);
      if (cand >= (OW+1)'(N_MASTERS)) cand = cand - (OW+1)'(N_MASTERS);
      if (!arb_found && arb_req[cand[OW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[OW-1:0];
      end
    end
  end

  // Ownership FSM: grant, direct handoff on release, watchdog abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      ptr         <= '0;
      wdog        <= '0;
      gnt_wb_o    <= '0;
      abort_first <= 1'b0;
    end else begin
      abort_first <= 1'b0;
      if (state == IDLE) begin
        if (arb_found) begin
          owner    <= arb_idx;
          gnt_wb_o <= ONE << arb_idx;
          state    <= OWNED;
          wdog     <= '0;
        end
      end else if (releasing) begin
        ptr  <= ptr_next;
        wdog <= '0;
        if (arb_found) begin
          owner    <= arb_idx;
          gnt_wb_o <= ONE << arb_idx;
          state    <= OWNED;
        end else begin
          gnt_wb_o <= '0;
          state    <= IDLE;
        end
      end else if (state == OWNED) begin
        if (S_ACK_I || S_RTY_I || S_ERR_I) begin
          wdog <= '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (wdog == WDOG_LAST) begin
            state       <= ABORT;
            abort_first <= 1'b1;
            wdog        <= '0;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
      end
    end
  end

  // Slave-side mux driven from the registered owner; cycle/strobe gated to OWNED.
  always_comb begin
    S_CYC_O = 1'b0;
    S_STB_O = 1'b0;
    S_WE_O  = 1'b0;
    S_ADR_O = '0;
    S_DAT_O = '0;
    S_SEL_O = '0;
    S_CTI_O = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (busy_o && owner == OW'(k)) begin
        S_CYC_O = (state == OWNED) && M_CYC_I[k];
        S_STB_O = (state == OWNED) && M_STB_I[k];
        S_WE_O  = M_WE_I[k];
        S_ADR_O = M_ADR_I[k*AW +: AW];
        S_DAT_O = M_DAT_I[k*DW +: DW];
        S_SEL_O = M_SEL_I[k*SW +: SW];
        S_CTI_O = M_CTI_I[k*3 +: 3];
      end
    end
  end

  // Master-side responses: only the owner sees the slave; everyone else is stalled.
  always_comb begin
    M_ACK_O   = '0;
    M_RTY_O   = '0;
    M_ERR_O   = '0;
    M_STALL_O = '1;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (owner == OW'(k)) begin
        if (state == OWNED) begin
          M_ACK_O[k]   = S_ACK_I;
          M_RTY_O[k]   = S_RTY_I;
          M_ERR_O[k]   = S_ERR_I;
          M_STALL_O[k] = S_STALL_I;
        end else if (state == ABORT) begin
          M_ERR_O[k]   = abort_first;
        end
      end
    end
  end

endmodule
